alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Sequencer for the bit-serial ALU datapath.
- Turns a single `on` start request into a fixed command sequence: datapath reset pulse, operand load, WIDTH serial bit cycles, then a done strobe.
- Cross-checks the datapath's `muxlast` indication against its own bit counter.
- Sits between the top-level start/opcode inputs and the serial ALU core; replaces ad-hoc reset and clock-phase generation with one clocked FSM.

Parameters:
- WIDTH, 8: operand width = number of serial bit cycles per operation (≥2).
- RST_CYC, 2: cycles `rstsig` is held high at the start of each operation (≥1).
- OPW, 3: opcode width.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst  in  1  synchronous active-high reset.
- on  in  1  start request, level; rising edge starts an operation.
- op  in  OPW  opcode; sampled on the accepted start edge.
- muxlast  in  1  datapath flag, high while its output mux is on the final bit.
- rstsig  out  1  datapath reset.
- load  out  1  one-cycle operand load strobe.
- shift_en  out  1  high for each serial bit cycle.
- bit_idx  out  $clog2(WIDTH)  index of current bit, LSB first.
- first_bit  out  1  high with bit_idx==0 (carry-in select).
- last_bit  out  1  high with bit_idx==WIDTH-1.
- mux_sel  out  OPW  latched opcode, stable for the whole operation.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion strobe.
- err  out  1  sticky muxlast/counter mismatch flag.

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; rstsig=0, load=0, shift_en=0, bit_idx=0, first_bit=0, last_bit=0, mux_sel=0, busy=0, done=0, err=0, on_q=0.
  - rst wins over every other event, including mid-operation: the next cycle is IDLE with all outputs at reset values.
- Start detect: start = on & ~on_q, with on_q registered every cycle. Holding `on` high starts exactly one operation. Edges while busy=1 are ignored and not queued.
- FSM, one state per cycle unless noted:
  - IDLE: on start → RST. Latch mux_sel=op, clear err, rst_cnt=0.
  - RST: rstsig=1 for RST_CYC cycles (rst_cnt counts 0..RST_CYC-1), then → LOAD.
  - LOAD: load=1 for one cycle; bit_idx=0; → SHIFT.
  - SHIFT: shift_en=1 for WIDTH consecutive cycles.
    - bit_idx increments 0..WIDTH-1.
    - first_bit = (bit_idx==0); last_bit = (bit_idx==WIDTH-1).
    - After the cycle with bit_idx==WIDTH-1 → DONE.
  - DONE: done=1 for one cycle, bit_idx→0, → IDLE.
- All outputs are registered (Moore) and decoded from state/counters; no combinational path from inputs to outputs.
- Latency: start edge at cycle t gives rstsig high t+1..t+RST_CYC, load at t+RST_CYC+1, shift_en t+RST_CYC+2..t+RST_CYC+WIDTH+1, done at t+RST_CYC+WIDTH+2. busy is high from t+1 through the done cycle.
- Back-to-back operations: a new start edge in the cycle after done (state IDLE) is accepted. Minimum issue interval is RST_CYC+WIDTH+3 cycles.
- muxlast check: in SHIFT, sample muxlast each cycle.
  - muxlast != last_bit → err=1 on the next cycle.
  - err stays set until the next accepted start or rst. The operation still completes.
  - muxlast is ignored outside SHIFT.
- mux_sel holds its value after DONE until the next accepted start. Changing `op` mid-operation has no effect.
- bit_idx never wraps inside SHIFT; it saturates logically at WIDTH-1 via the state exit.

Decomposition:
- Package alu_pkg holds:
  - the state enum: IDLE, RST, LOAD, SHIFT, DONE;
  - the WIDTH, RST_CYC and OPW defaults;
  - the BIT_IDX_W = $clog2(WIDTH) localparam.
- One natural sub-module, seq_edge_det: the `on` rising-edge detector with sync-reset on_q. Reused by other start/trigger inputs.
- Counters stay inline in the FSM.

Test Plan:
- Reset, then on=1 held for 5 cycles with op=3'b101 (WIDTH=8, RST_CYC=2) → rstsig at cycles 1-2, load at 3, shift_en 4-11 with bit_idx 0..7, first_bit at 4, last_bit at 11, done at 12. mux_sel=5 throughout; exactly one operation runs.
- Start, then muxlast driven high at bit_idx==3 only → err=1 from the cycle after bit 3 and stays 1 after done. A clean second operation clears err at its start.
- Correct muxlast (high only at bit 7) → err stays 0 for the whole operation.
- Pulse on again at bit_idx==4 → ignored; only one done. Re-pulse on the cycle after done → a second operation starts and done follows 12 cycles later.
- Assert rst for 1 cycle at bit_idx==5 → next cycle busy=0, shift_en=0, bit_idx=0, done never asserted. A later start runs normally.
- Change op from 3'b001 to 3'b110 during SHIFT → mux_sel stays 1 until the next start, then becomes 6.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and defaults for the bit-serial ALU sequencer.
package alu_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_RST_CYC = 2;
  localparam int DEF_OPW     = 3;
  localparam int BIT_IDX_W   = $clog2(DEF_WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/seq_edge_det.sv
// Rising-edge detector for level start/trigger inputs; the history flop clears on reset.
module seq_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // History of the input, one cycle behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the bit-serial ALU: reset pulse, operand load, WIDTH
// serial bit cycles and a done strobe, with a muxlast-versus-counter cross-check.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int OPW     = DEF_OPW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     on,
  input  logic [OPW-1:0]           op,
  input  logic                     muxlast,
  output logic                     rstsig,
  output logic                     load,
  output logic                     shift_en,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     first_bit,
  output logic                     last_bit,
  output logic [OPW-1:0]           mux_sel,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] PREV_IDX = IDX_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] LAST_RST = CNT_W'(RST_CYC - 1);

  state_e           state_q;
  logic [CNT_W-1:0] rst_cnt_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic [OPW-1:0]   mux_sel_q;
  logic             rstsig_q;
  logic             load_q;
  logic             shift_en_q;
  logic             first_bit_q;
  logic             last_bit_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             start_s;

  seq_edge_det u_on_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (on),
    .rise_o (start_s)
  );

  // Sequencer FSM; every output is a flop updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rst_cnt_q   <= '0;
      bit_idx_q   <= '0;
      mux_sel_q   <= '0;
      rstsig_q    <= 1'b0;
      load_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      first_bit_q <= 1'b0;
      last_bit_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            state_q   <= RST;
            rst_cnt_q <= '0;
            mux_sel_q <= op;
            err_q     <= 1'b0;
            rstsig_q  <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        RST: begin
          if (rst_cnt_q == LAST_RST) begin
            state_q  <= LOAD;
            rstsig_q <= 1'b0;
            load_q   <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + CNT_W'(1);
          end
        end
        LOAD: begin
          state_q     <= SHIFT;
          load_q      <= 1'b0;
          shift_en_q  <= 1'b1;
          bit_idx_q   <= '0;
          first_bit_q <= 1'b1;
          last_bit_q  <= 1'b0;
        end
        SHIFT: begin
          // The datapath's final-bit flag must track our own counter exactly.
          if (muxlast != last_bit_q) begin
            err_q <= 1'b1;
          end
          first_bit_q <= 1'b0;
          if (bit_idx_q == LAST_IDX) begin
            state_q    <= DONE;
            shift_en_q <= 1'b0;
            bit_idx_q  <= '0;
            last_bit_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            bit_idx_q  <= bit_idx_q + IDX_W'(1);
            last_bit_q <= (bit_idx_q == PREV_IDX);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          rst_cnt_q   <= '0;
          bit_idx_q   <= '0;
          rstsig_q    <= 1'b0;
          load_q      <= 1'b0;
          shift_en_q  <= 1'b0;
          first_bit_q <= 1'b0;
          last_bit_q  <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign rstsig    = rstsig_q;
  assign load      = load_q;
  assign shift_en  = shift_en_q;
  assign bit_idx   = bit_idx_q;
  assign first_bit = first_bit_q;
  assign last_bit  = last_bit_q;
  assign mux_sel   = mux_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl at WIDTH=8, RST_CYC=2, OPW=3.
module tb_alu_seq_ctrl;

  localparam int W  = 8;
  localparam int RC = 2;
  localparam int SS = RC + 2;      // first shift cycle after the start edge
  localparam int SE = RC + W + 1;  // last shift cycle
  localparam int DK = RC + W + 2;  // done cycle

  logic       clk = 1'b0;
  logic       rst;
  logic       on;
  logic [2:0] op;
  logic       muxlast;
  logic       rstsig, load, shift_en, first_bit, last_bit, busy, done, err;
  logic [2:0] bit_idx;
  logic [2:0] mux_sel;

  int n_checks = 0;
  int n_errors = 0;
  int cur_k    = 0;

  alu_seq_ctrl #(.WIDTH(W), .RST_CYC(RC), .OPW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .on        (on),
    .op        (op),
    .muxlast   (muxlast),
    .rstsig    (rstsig),
    .load      (load),
    .shift_en  (shift_en),
    .bit_idx   (bit_idx),
    .first_bit (first_bit),
    .last_bit  (last_bit),
    .mux_sel   (mux_sel),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s (k=%0d, t=%0t): got %0h expected %0h", tag, cur_k, $time, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs k cycles after the accepted start edge.
  task automatic chk_sched(input int k, input logic exp_err, input logic [2:0] exp_sel);
    cur_k = k;
    chk_eq("rstsig",    32'(rstsig),    32'(k >= 1 && k <= RC));
    chk_eq("load",      32'(load),      32'(k == RC + 1));
    chk_eq("shift_en",  32'(shift_en),  32'(k >= SS && k <= SE));
    chk_eq("bit_idx",   32'(bit_idx),   (k >= SS && k <= SE) ? 32'(k - SS) : 32'd0);
    chk_eq("first_bit", 32'(first_bit), 32'(k == SS));
    chk_eq("last_bit",  32'(last_bit),  32'(k == SE));
    chk_eq("done",      32'(done),      32'(k == DK));
    chk_eq("busy",      32'(busy),      32'(k >= 1 && k <= DK));
    chk_eq("mux_sel",   32'(mux_sel),   32'(exp_sel));
    chk_eq("err",       32'(err),       32'(exp_err));
  endtask

  // One operation: on high for cycles 0..hold-1 plus a pulse at pulse_k; muxlast
  // correct unless bad_k>0, in which case it is high only in cycle bad_k.
  task automatic run_op(input logic [2:0] opv, input int hold, input int bad_k,
                        input int pulse_k, input int chg_k, input logic [2:0] chg_op,
                        input logic [2:0] exp_sel);
    op      = opv;
    on      = 1'b1;
    muxlast = 1'b0;
    for (int k = 1; k <= DK; k++) begin
      step();
      on = (k < hold) || (k == pulse_k);
      chk_sched(k, (bad_k != 0) && (k > bad_k), exp_sel);
      muxlast = (bad_k != 0) ? (k == bad_k) : (k == SE);
      if (k == chg_k) op = chg_op;
    end
    muxlast = 1'b0;
  endtask

  task automatic idle_check(input int n, input logic exp_err, input logic [2:0] exp_sel);
    for (int i = 0; i < n; i++) begin
      step();
      cur_k = 100 + i;
      chk_eq("idle_busy",   32'(busy),     32'd0);
      chk_eq("idle_done",   32'(done),     32'd0);
      chk_eq("idle_shift",  32'(shift_en), 32'd0);
      chk_eq("idle_rstsig", 32'(rstsig),   32'd0);
      chk_eq("idle_sel",    32'(mux_sel),  32'(exp_sel));
      chk_eq("idle_err",    32'(err),      32'(exp_err));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_busy"},   32'(busy),      32'd0);
    chk_eq({tag, "_shift"},  32'(shift_en),  32'd0);
    chk_eq({tag, "_idx"},    32'(bit_idx),   32'd0);
    chk_eq({tag, "_done"},   32'(done),      32'd0);
    chk_eq({tag, "_rstsig"}, 32'(rstsig),    32'd0);
    chk_eq({tag, "_load"},   32'(load),      32'd0);
    chk_eq({tag, "_first"},  32'(first_bit), 32'd0);
    chk_eq({tag, "_last"},   32'(last_bit),  32'd0);
    chk_eq({tag, "_sel"},    32'(mux_sel),   32'd0);
    chk_eq({tag, "_err"},    32'(err),       32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    on      = 1'b0;
    op      = 3'd0;
    muxlast = 1'b0;
    step();
    step();
    cur_k = 0;
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // on held 5 cycles, correct muxlast: one clean operation with mux_sel=5
    run_op(3'b101, 5, 0, 0, 0, 3'd0, 3'b101);
    idle_check(3, 1'b0, 3'b101);

    // muxlast wrong at bit 3 (cycle 7): err from cycle 8, sticky past done
    run_op(3'b010, 1, 7, 0, 0, 3'd0, 3'b010);
    idle_check(2, 1'b1, 3'b010);
    run_op(3'b011, 1, 0, 0, 0, 3'd0, 3'b011);
    idle_check(1, 1'b0, 3'b011);

    // re-pulse at bit 4 ignored; pulse in the cycle after done is accepted
    run_op(3'b100, 1, 0, SS + 4, 0, 3'd0, 3'b100);
    idle_check(1, 1'b0, 3'b100);
    run_op(3'b100, 1, 0, 0, 0, 3'd0, 3'b100);
    idle_check(2, 1'b0, 3'b100);

    // rst for one cycle at bit 5 aborts the operation
    op = 3'b010;
    on = 1'b1;
    for (int k = 1; k <= SS + 5; k++) begin
      step();
      on = 1'b0;
      chk_sched(k, 1'b0, 3'b010);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cur_k = 200;
    chk_all_zero("abort");
    idle_check(4, 1'b0, 3'd0);
    run_op(3'b111, 1, 0, 0, 0, 3'd0, 3'b111);
    idle_check(1, 1'b0, 3'b111);

    // op changed mid-SHIFT has no effect until the next start
    run_op(3'b001, 1, 0, 0, SS + 2, 3'b110, 3'b001);
    idle_check(2, 1'b0, 3'b001);
    run_op(3'b110, 1, 0, 0, 0, 3'd0, 3'b110);

    // on held high well past done: no second operation
    idle_check(1, 1'b0, 3'b110);
    run_op(3'b011, 40, 0, 0, 0, 3'd0, 3'b011);
    idle_check(4, 1'b0, 3'b011);
    on = 1'b0;
    idle_check(1, 1'b0, 3'b011);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
